// File: rtl/wiper_ctrl_p.sv
// -----------------------------------------------------------------------------
// wiper_ctrl_p
// Parametrised rain-sensing windshield-wiper controller.
//   - counts wet drop sensors (combinational popcount)
//   - qualifies SLOW/FAST thresholds over consecutive sample ticks
//   - manual mode override (auto / force OFF / force SLOW / force FAST)
//   - optional downgrade hysteresis, enabled by defining WIPER_HYST_EN
//   - periodic one-cycle sweep pulses and a wrapping sweep counter
//
// Ports
//   clk_2       in   single clock, rising edge
//   reset       in   asynchronous, active-high
//   tick        in   sample enable; counters and FSM advance only when 1
//   drops       in   [NSENSORS] drop sensors, 1 = wet
//   mode        in   [2] 00 auto, 01 OFF, 10 SLOW, 11 FAST
//   num_drops   out  [$clog2(NSENSORS+1)] popcount of drops
//   state       out  [2] 0 OFF, 1 SLOW, 2 FAST
//   wiper_on    out  state != OFF
//   wiper_fast  out  state == FAST
//   sweep       out  one-cycle wipe pulse after a sweeping tick edge
//   sweep_count out  [SWEEP_W] sweeps issued, modulo 2^SWEEP_W
//
// Build option: WIPER_HYST_EN adds a DOWN_HOLD-tick delay on downgrades.
// -----------------------------------------------------------------------------
module wiper_ctrl_p #(
  parameter int unsigned NSENSORS    = 7,
  parameter int unsigned SLOW_TH     = 4,
  parameter int unsigned FAST_TH     = 6,
  parameter int unsigned SLOW_HOLD   = 3,
  parameter int unsigned FAST_HOLD   = 2,
  parameter int unsigned DOWN_HOLD   = 4,
  parameter int unsigned SLOW_PERIOD = 8,
  parameter int unsigned FAST_PERIOD = 3,
  parameter int unsigned SWEEP_W     = 8,
  localparam int unsigned NDW        = $clog2(NSENSORS + 1)
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic                tick,
  input  logic [NSENSORS-1:0] drops,
  input  logic [1:0]          mode,
  output logic [NDW-1:0]      num_drops,
  output logic [1:0]          state,
  output logic                wiper_on,
  output logic                wiper_fast,
  output logic                sweep,
  output logic [SWEEP_W-1:0]  sweep_count
);

  localparam int unsigned CSW = $clog2(SLOW_HOLD + 1);
  localparam int unsigned CFW = $clog2(FAST_HOLD + 1);
  localparam int unsigned PW  = $clog2(SLOW_PERIOD);

  localparam logic [NDW-1:0] SLOW_TH_N   = NDW'(SLOW_TH);
  localparam logic [NDW-1:0] FAST_TH_N   = NDW'(FAST_TH);
  localparam logic [CSW-1:0] SLOW_HOLD_C = CSW'(SLOW_HOLD);
  localparam logic [CFW-1:0] FAST_HOLD_C = CFW'(FAST_HOLD);
  localparam logic [PW-1:0]  SLOW_LAST   = PW'(SLOW_PERIOD - 1);
  localparam logic [PW-1:0]  FAST_LAST   = PW'(FAST_PERIOD - 1);

  if (NSENSORS < 2 || FAST_TH <= SLOW_TH || FAST_TH > NSENSORS ||
      SLOW_HOLD < 1 || FAST_HOLD < 1 || DOWN_HOLD < 1 ||
      SLOW_PERIOD < 2 || FAST_PERIOD < 1 || FAST_PERIOD >= SLOW_PERIOD)
  begin : g_param_check
    $error("wiper_ctrl_p: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } state_t;

  state_t             state_q, state_d, target, ns;
  logic [CSW-1:0]     cnt_slow_q, cnt_slow_d, cnt_slow_nxt;
  logic [CFW-1:0]     cnt_fast_q, cnt_fast_d, cnt_fast_nxt;
  logic [PW-1:0]      phase_q, phase_d, phase_nxt, phase_last;
  logic               sweep_q, sweep_d, do_sweep;
  logic [SWEEP_W-1:0] sweep_count_q, sweep_count_d;
  logic               q_slow, q_fast;

`ifdef WIPER_HYST_EN
  localparam int unsigned DW = $clog2(DOWN_HOLD + 1);
  localparam logic [DW-1:0] DOWN_LAST = DW'(DOWN_HOLD - 1);
  logic [DW-1:0] down_q, down_d, down_nxt;
`endif

  always_comb begin
    num_drops = '0;
    for (int unsigned i = 0; i < NSENSORS; i++) begin
      num_drops = num_drops + NDW'(drops[i]);
    end
  end

  always_comb begin
    q_slow = (num_drops >= SLOW_TH_N);
    q_fast = (num_drops >= FAST_TH_N);

    cnt_slow_nxt = '0;
    if (q_slow) begin
      cnt_slow_nxt = (cnt_slow_q == SLOW_HOLD_C) ? cnt_slow_q : cnt_slow_q + 1'b1;
    end
    cnt_fast_nxt = '0;
    if (q_fast) begin
      cnt_fast_nxt = (cnt_fast_q == FAST_HOLD_C) ? cnt_fast_q : cnt_fast_q + 1'b1;
    end

    // target is judged on the counts as they will be after this tick
    target = ST_OFF;
    if (cnt_fast_nxt == FAST_HOLD_C) begin
      target = ST_FAST;
    end else if (cnt_slow_nxt == SLOW_HOLD_C) begin
      target = ST_SLOW;
    end

    ns = state_q;
`ifdef WIPER_HYST_EN
    down_nxt = '0;
`endif
    case (mode)
      2'b01:   ns = ST_OFF;
      2'b10:   ns = ST_SLOW;
      2'b11:   ns = ST_FAST;
      default: begin
        if (target >= state_q) begin
          ns = target;
        end else begin
`ifdef WIPER_HYST_EN
          if (down_q == DOWN_LAST) begin
            ns = target;
          end else begin
            down_nxt = down_q + 1'b1;
          end
`else
          ns = target;
`endif
        end
      end
    endcase

    // sweep timing follows the period of the state being entered
    phase_last = (ns == ST_FAST) ? FAST_LAST : SLOW_LAST;
    phase_nxt  = '0;
    do_sweep   = 1'b0;
    if (ns == ST_OFF) begin
      do_sweep = 1'b0;
    end else if (state_q == ST_OFF) begin
      do_sweep = 1'b1;
    end else if (phase_q >= phase_last) begin
      do_sweep = 1'b1;
    end else begin
      phase_nxt = phase_q + 1'b1;
    end

    state_d       = state_q;
    cnt_slow_d    = cnt_slow_q;
    cnt_fast_d    = cnt_fast_q;
    phase_d       = phase_q;
    sweep_d       = 1'b0;
    sweep_count_d = sweep_count_q;
`ifdef WIPER_HYST_EN
    down_d        = down_q;
`endif
    if (tick) begin
      state_d    = ns;
      cnt_slow_d = cnt_slow_nxt;
      cnt_fast_d = cnt_fast_nxt;
      phase_d    = phase_nxt;
      sweep_d    = do_sweep;
      if (do_sweep) begin
        sweep_count_d = sweep_count_q + 1'b1;
      end
`ifdef WIPER_HYST_EN
      down_d     = down_nxt;
`endif
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_OFF;
      cnt_slow_q    <= '0;
      cnt_fast_q    <= '0;
      phase_q       <= '0;
      sweep_q       <= 1'b0;
      sweep_count_q <= '0;
`ifdef WIPER_HYST_EN
      down_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_slow_q    <= cnt_slow_d;
      cnt_fast_q    <= cnt_fast_d;
      phase_q       <= phase_d;
      sweep_q       <= sweep_d;
      sweep_count_q <= sweep_count_d;
`ifdef WIPER_HYST_EN
      down_q        <= down_d;
`endif
    end
  end

  assign state       = state_q;
  assign wiper_on    = (state_q != ST_OFF);
  assign wiper_fast  = (state_q == ST_FAST);
  assign sweep       = sweep_q;
  assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_wiper_ctrl_p.sv
// -----------------------------------------------------------------------------
// tb_wiper_ctrl_p
// Self-checking bench for wiper_ctrl_p (default parameters, SWEEP_W = 2 so the
// sweep counter wraps quickly). Expected outputs come from a cycle model and
// are queued when a cycle is driven, then popped and compared after the edge.
// -----------------------------------------------------------------------------
module tb_wiper_ctrl_p;

  localparam int SLOW_TH     = 4;
  localparam int FAST_TH     = 6;
  localparam int SLOW_HOLD   = 3;
  localparam int FAST_HOLD   = 2;
  localparam int DOWN_HOLD   = 4;
  localparam int SLOW_PERIOD = 8;
  localparam int FAST_PERIOD = 3;

  localparam logic [6:0] DRY = 7'b0000000;
  localparam logic [6:0] W3  = 7'b0000111;
  localparam logic [6:0] W4  = 7'b0001111;
  localparam logic [6:0] W6  = 7'b0111111;
  localparam logic [6:0] ALL = 7'b1111111;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic       tick  = 1'b0;
  logic [6:0] drops = '0;
  logic [1:0] mode  = '0;
  logic [2:0] num_drops;
  logic [1:0] state;
  logic       wiper_on, wiper_fast, sweep;
  logic [1:0] sweep_count;

  wiper_ctrl_p #(
    .NSENSORS(7), .SLOW_TH(SLOW_TH), .FAST_TH(FAST_TH),
    .SLOW_HOLD(SLOW_HOLD), .FAST_HOLD(FAST_HOLD), .DOWN_HOLD(DOWN_HOLD),
    .SLOW_PERIOD(SLOW_PERIOD), .FAST_PERIOD(FAST_PERIOD), .SWEEP_W(2)
  ) dut (
    .clk_2(clk_2), .reset(reset), .tick(tick), .drops(drops), .mode(mode),
    .num_drops(num_drops), .state(state), .wiper_on(wiper_on),
    .wiper_fast(wiper_fast), .sweep(sweep), .sweep_count(sweep_count)
  );

  always #5 clk_2 = ~clk_2;

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] exp_q[$];

  // reference model state
  int m_st, m_cs, m_cf, m_dn, m_ph, m_cnt;
  bit m_sw;

  function automatic void model_reset();
    m_st = 0; m_cs = 0; m_cf = 0; m_dn = 0; m_ph = 0; m_cnt = 0; m_sw = 0;
  endfunction

  function automatic void model_step(input logic [6:0] d, input logic [1:0] m, input logic t);
    int n, tgt, ns, per;
    if (!t) begin
      m_sw = 0;
      return;
    end
    n = $countones(d);
    m_cs = (n >= SLOW_TH) ? ((m_cs < SLOW_HOLD) ? m_cs + 1 : m_cs) : 0;
    m_cf = (n >= FAST_TH) ? ((m_cf < FAST_HOLD) ? m_cf + 1 : m_cf) : 0;
    tgt = (m_cf == FAST_HOLD) ? 2 : (m_cs == SLOW_HOLD) ? 1 : 0;
    if (m != 2'b00) begin
      ns = int'(m) - 1;
      m_dn = 0;
    end else if (tgt >= m_st) begin
      ns = tgt;
      m_dn = 0;
    end else begin
`ifdef WIPER_HYST_EN
      m_dn = m_dn + 1;
      if (m_dn >= DOWN_HOLD) begin
        ns = tgt;
        m_dn = 0;
      end else begin
        ns = m_st;
      end
`else
      ns = tgt;
`endif
    end
    per = (ns == 2) ? FAST_PERIOD : SLOW_PERIOD;
    if (ns == 0) begin
      m_ph = 0; m_sw = 0;
    end else if (m_st == 0 || m_ph >= per - 1) begin
      m_ph = 0; m_sw = 1;
    end else begin
      m_ph = m_ph + 1; m_sw = 0;
    end
    if (m_sw) m_cnt = (m_cnt + 1) % 4;
    m_st = ns;
  endfunction

  function automatic logic [6:0] model_obs();
    return {2'(m_st), (m_st != 0), (m_st == 2), m_sw, 2'(m_cnt)};
  endfunction

  function automatic logic [6:0] dut_obs();
    return {state, wiper_on, wiper_fast, sweep, sweep_count};
  endfunction

  task automatic drive(input logic [6:0] d, input logic [1:0] m, input logic t);
    drops = d; mode = m; tick = t;
    model_step(d, m, t);
    exp_q.push_back(model_obs());
    @(posedge clk_2);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; tick = 1'b0; drops = '0; mode = '0;
    model_reset();
    exp_q.delete();
    @(posedge clk_2);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    #1 reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (dut_obs() !== 7'd0) begin
      n_err++;
      $display("FAIL reset_values: got %h want %h", dut_obs(), 7'd0);
    end
    @(posedge clk_2);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(ALL, 2'b11, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_err++;
        $display("FAIL reset_no_tick %0d: got %h want %h", i, dut_obs(), e);
      end
    end
  endtask

  task automatic test_popcount();
    logic [6:0] pats [6] = '{7'h00, 7'h01, 7'h55, 7'h7f, 7'h40, 7'h3c};
    int exp_n;
    tick = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drops = pats[i];
      #1;
      exp_n = $countones(pats[i]);
      n_cmp++;
      if (num_drops !== 3'(exp_n)) begin
        n_err++;
        $display("FAIL popcount %h: got %0d want %0d", pats[i], num_drops, exp_n);
      end
    end
    @(posedge clk_2);
    #1;
  endtask

  task automatic test_fast_entry();
    logic [6:0] e;
    logic [7:0] mask = '0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(W6, 2'b00, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_err++;
        $display("FAIL fast_entry tick %0d: got %h want %h", i, dut_obs(), e);
      end
      mask[i] = sweep;
      if (i == 1) begin
        n_cmp++;
        if ({state, sweep, sweep_count} !== {2'd2, 1'b1, 2'd1}) begin
          n_err++;
          $display("FAIL fast_entry_first: got %b want %b", {state, sweep, sweep_count}, 5'b10101);
        end
      end
    end
    n_cmp++;
    if (mask !== 8'b1001_0010) begin
      n_err++;
      $display("FAIL fast_period: got %b want %b", mask, 8'b1001_0010);
    end
  endtask

  task automatic test_slow_qual();
    logic [6:0] e;
    logic [6:0] pre [6] = '{W4, W4, W3, W4, W4, W4};
    logic [15:0] mask = '0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(pre[i], 2'b00, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_err++;
        $display("FAIL slow_qual tick %0d: got %h want %h", i, dut_obs(), e);
      end
      if (i == 4) begin
        n_cmp++;
        if (state !== 2'd0) begin
          n_err++;
          $display("FAIL slow_not_yet: got %0d want 0", state);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if ({state, sweep} !== {2'd1, 1'b1}) begin
          n_err++;
          $display("FAIL slow_entry: got %b want %b", {state, sweep}, 3'b011);
        end
      end
      // inputs changing between ticks must be ignored
      drive(ALL, 2'b11, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_err++;
        $display("FAIL between_ticks %0d: got %h want %h", i, dut_obs(), e);
      end
    end
    for (int j = 0; j < 16; j++) begin
      drive(W4, 2'b00, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_err++;
        $display("FAIL slow_run tick %0d: got %h want %h", j, dut_obs(), e);
      end
      mask[j] = sweep;
    end
    n_cmp++;
    if (mask !== 16'h8080) begin
      n_err++;
      $display("FAIL slow_period: got %h want %h", mask, 16'h8080);
    end
  endtask

  // continues from the SLOW state left by test_slow_qual
  task automatic test_force();
    logic [6:0] e;
    logic [7:0] rec = '0;
    logic [7:0] want;
    drive(W4, 2'b11, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if (dut_obs() !== e || state !== 2'd2) begin
      n_err++;
      $display("FAIL force_fast: got %h want %h", dut_obs(), e);
    end
    for (int i = 0; i < 4; i++) begin
      drive(W4, 2'b00, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_err++;
        $display("FAIL force_release %0d: got %h want %h", i, dut_obs(), e);
      end
      rec = {rec[5:0], state};
    end
`ifdef WIPER_HYST_EN
    want = 8'b10_10_10_01;
`else
    want = 8'b01_01_01_01;
`endif
    n_cmp++;
    if (rec !== want) begin
      n_err++;
      $display("FAIL force_return_auto: got %b want %b", rec, want);
    end
    drive(W6, 2'b01, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if (dut_obs() !== e || {state, wiper_on, sweep} !== 4'b0000) begin
      n_err++;
      $display("FAIL force_off: got %h want %h", dut_obs(), e);
    end
  endtask

  task automatic test_downgrade();
    logic [6:0] e;
    logic [6:0] seq [7] = '{DRY, W6, W6, DRY, DRY, DRY, DRY};
    logic [13:0] rec = '0;
    logic [13:0] want;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      drive(W6, 2'b00, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_err++;
        $display("FAIL down_setup %0d: got %h want %h", i, dut_obs(), e);
      end
    end
    for (int i = 0; i < 7; i++) begin
      drive(seq[i], 2'b00, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_err++;
        $display("FAIL downgrade tick %0d: got %h want %h", i, dut_obs(), e);
      end
      rec = {rec[11:0], state};
    end
`ifdef WIPER_HYST_EN
    want = 14'b10_10_10_10_10_10_00;
`else
    want = 14'b00_00_10_00_00_00_00;
`endif
    n_cmp++;
    if (rec !== want) begin
      n_err++;
      $display("FAIL downgrade_seq: got %b want %b", rec, want);
    end
  endtask

  task automatic test_wrap();
    logic [6:0] e;
    logic [9:0] got = '0;
    int nsw = 0;
    apply_reset();
    for (int i = 0; i < 20 && nsw < 5; i++) begin
      drive(W6, 2'b00, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_err++;
        $display("FAIL wrap tick %0d: got %h want %h", i, dut_obs(), e);
      end
      if (sweep === 1'b1) begin
        got = {got[7:0], sweep_count};
        nsw++;
      end
    end
    n_cmp++;
    if (nsw != 5 || got !== 10'b01_10_11_00_01) begin
      n_err++;
      $display("FAIL wrap_seq: got %0d sweeps %b want 5 sweeps %b", nsw, got, 10'b01_10_11_00_01);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    logic [5:0] rec = '0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(W4, 2'b00, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_err++;
        $display("FAIL pre_reset %0d: got %h want %h", i, dut_obs(), e);
      end
    end
    reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (dut_obs() !== 7'd0) begin
      n_err++;
      $display("FAIL reset_mid_sweep: got %h want %h", dut_obs(), 7'd0);
    end
    @(posedge clk_2);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(W4, 2'b00, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_err++;
        $display("FAIL post_reset %0d: got %h want %h", i, dut_obs(), e);
      end
      rec = {rec[3:0], state};
    end
    n_cmp++;
    if (rec !== 6'b00_00_01) begin
      n_err++;
      $display("FAIL requalify: got %b want %b", rec, 6'b00_00_01);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_popcount();
    test_fast_entry();
    test_slow_qual();
    test_force();
    test_downgrade();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
